// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if
//  Bundles the fetch handshake, data-memory ready, trap release and every
//  datapath control output of the multicycle controller.
//  Parameters:
//   ALUOP_W  width of ALUOp (>= 3, upper bits always zero)
//   CNT_W    width of the retired-instruction counter
//  Modports:
//   master   fetch / datapath side: drives instr_valid, Opcode, mem_ready,
//            trap_clear; observes all controller outputs
//   slave    the controller itself
interface multicycle_controller_if #(
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 32
);
    logic               instr_valid;
    logic [6:0]         Opcode;
    logic               mem_ready;
    logic               trap_clear;

    logic               instr_ready;
    logic               IRWrite;
    logic               ALUSrc;
    logic               MemtoReg;
    logic               RegWrite;
    logic               MemRead;
    logic               MemWrite;
    logic               Branch;
    logic               Jump;
    logic               CurrFlag;
    logic [ALUOP_W-1:0] ALUOp;
    logic               PCWrite;
    logic               Illegal;
    logic [CNT_W-1:0]   instret;
    logic [2:0]         state_o;

    modport master (
        output instr_valid, Opcode, mem_ready, trap_clear,
        input  instr_ready, IRWrite, ALUSrc, MemtoReg, RegWrite, MemRead,
               MemWrite, Branch, Jump, CurrFlag, ALUOp, PCWrite, Illegal,
               instret, state_o
    );

    modport slave (
        input  instr_valid, Opcode, mem_ready, trap_clear,
        output instr_ready, IRWrite, ALUSrc, MemtoReg, RegWrite, MemRead,
               MemWrite, Branch, Jump, CurrFlag, ALUOp, PCWrite, Illegal,
               instret, state_o
    );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller
//  Multicycle FSM controller: latches the opcode on a fetch handshake, steps
//  FETCH/DECODE/EXEC/MEM/WB, waits on data-memory ready with an optional
//  timeout, traps illegal opcodes and counts retired instructions.
//  Parameters:
//   ALUOP_W      ALUOp width (>= 3)
//   EXT_UPPER    1: LUI/AUIPC legal, 0: they trap
//   MEM_TIMEOUT  MEM cycles without mem_ready before TRAP (0 = never)
//   CNT_W        retired-instruction counter width
//  Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    slave side of multicycle_controller_if (handshake, memory ready,
//          trap release, control outputs, instret, state_o)
module multicycle_controller #(
    parameter int ALUOP_W     = 3,
    parameter int EXT_UPPER   = 0,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_controller_if.slave bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [2:0] ALU_I    = 3'b000;
    localparam logic [2:0] ALU_BR   = 3'b001;
    localparam logic [2:0] ALU_R    = 3'b010;
    localparam logic [2:0] ALU_MEM  = 3'b100;
    localparam logic [2:0] ALU_UP   = 3'b110;
    localparam logic [2:0] ALU_JMP  = 3'b111;

    localparam int TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t             state;
    state_t             next_state;
    logic [6:0]         opcode_q;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [CNT_W-1:0]   instret_q;

    logic instr_ready, ir_write, alu_src, mem_to_reg, reg_write;
    logic mem_read, mem_write, branch, jump, curr_flag, pc_write, illegal;
    logic [ALUOP_W-1:0] alu_op;

    logic is_r, is_i, is_lw, is_sw, is_br, is_jal, is_jalr, is_upper, is_legal;

    // Classes come only from the latched opcode so every output stays Moore
    // with respect to Opcode.
    assign is_r     = (opcode_q == OP_R);
    assign is_i     = (opcode_q == OP_I);
    assign is_lw    = (opcode_q == OP_LW);
    assign is_sw    = (opcode_q == OP_SW);
    assign is_br    = (opcode_q == OP_BR);
    assign is_jal   = (opcode_q == OP_JAL);
    assign is_jalr  = (opcode_q == OP_JALR);
    assign is_upper = (EXT_UPPER != 0) && ((opcode_q == OP_LUI) || (opcode_q == OP_AUIPC));
    assign is_legal = is_r | is_i | is_lw | is_sw | is_br | is_jal | is_jalr | is_upper;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // The timeout counter restarts whenever we are outside MEM, so it is
    // already zero on the first MEM cycle of every load/store.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opcode_q  <= '0;
            tmo_cnt   <= '0;
            instret_q <= '0;
        end else begin
            if ((state == S_FETCH) && bus.instr_valid) begin
                opcode_q <= bus.Opcode;
            end
            if (state != S_MEM) begin
                tmo_cnt <= '0;
            end else if (!bus.mem_ready && (MEM_TIMEOUT != 0)) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (pc_write) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    // Next state and control decode. Everything is forced low while reset is
    // asserted, which also keeps instr_ready low until release.
    always_comb begin
        next_state  = state;
        instr_ready = 1'b0;
        ir_write    = 1'b0;
        alu_src     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        branch      = 1'b0;
        jump        = 1'b0;
        curr_flag   = 1'b0;
        pc_write    = 1'b0;
        illegal     = 1'b0;
        alu_op      = '0;
        if (reset) begin
            case (state)
                S_FETCH: begin
                    instr_ready = 1'b1;
                    if (bus.instr_valid) begin
                        ir_write   = 1'b1;
                        next_state = S_DECODE;
                    end
                end
                S_DECODE: begin
                    next_state = is_legal ? S_EXEC : S_TRAP;
                end
                S_EXEC: begin
                    if (is_r) begin
                        alu_op = ALUOP_W'(ALU_R);
                    end else if (is_i) begin
                        alu_src = 1'b1;
                        alu_op  = ALUOP_W'(ALU_I);
                    end else if (is_lw || is_sw) begin
                        alu_src = 1'b1;
                        alu_op  = ALUOP_W'(ALU_MEM);
                    end else if (is_br) begin
                        alu_op = ALUOP_W'(ALU_BR);
                        branch = 1'b1;
                    end else if (is_jal || is_jalr) begin
                        alu_src   = 1'b1;
                        alu_op    = ALUOP_W'(ALU_JMP);
                        jump      = 1'b1;
                        curr_flag = is_jalr;
                    end else begin
                        alu_src = 1'b1;
                        alu_op  = ALUOP_W'(ALU_UP);
                    end
                    if (is_br) begin
                        pc_write   = 1'b1;
                        next_state = S_FETCH;
                    end else if (is_lw || is_sw) begin
                        next_state = S_MEM;
                    end else begin
                        next_state = S_WB;
                    end
                end
                S_MEM: begin
                    alu_src   = 1'b1;
                    alu_op    = ALUOP_W'(ALU_MEM);
                    mem_read  = is_lw;
                    mem_write = is_sw;
                    // A ready arriving on the timeout cycle still completes.
                    if (bus.mem_ready) begin
                        if (is_sw) begin
                            pc_write   = 1'b1;
                            next_state = S_FETCH;
                        end else begin
                            next_state = S_WB;
                        end
                    end else if ((MEM_TIMEOUT != 0) && (tmo_cnt == TMO_LAST)) begin
                        next_state = S_TRAP;
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = is_lw;
                    jump       = is_jal | is_jalr;
                    curr_flag  = is_jalr;
                    pc_write   = 1'b1;
                    next_state = S_FETCH;
                end
                S_TRAP: begin
                    illegal = 1'b1;
                    if (bus.trap_clear) begin
                        next_state = S_FETCH;
                    end
                end
                default: begin
                    next_state = S_FETCH;
                end
            endcase
        end
    end

    assign bus.instr_ready = instr_ready;
    assign bus.IRWrite     = ir_write;
    assign bus.ALUSrc      = alu_src;
    assign bus.MemtoReg    = mem_to_reg;
    assign bus.RegWrite    = reg_write;
    assign bus.MemRead     = mem_read;
    assign bus.MemWrite    = mem_write;
    assign bus.Branch      = branch;
    assign bus.Jump        = jump;
    assign bus.CurrFlag    = curr_flag;
    assign bus.ALUOp       = alu_op;
    assign bus.PCWrite     = pc_write;
    assign bus.Illegal     = illegal;
    assign bus.instret     = instret_q;
    assign bus.state_o     = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
//  Two controller builds share one clock and reset:
//   dut_a  EXT_UPPER=0, MEM_TIMEOUT=4,  CNT_W=4,  ALUOP_W=3
//   dut_b  EXT_UPPER=1, MEM_TIMEOUT=15, CNT_W=32, ALUOP_W=4
//  'sel' routes stimulus to one of them; the other idles in FETCH.
//  For each instruction the bench builds the full expected cycle trace from
//  the instruction class and wait count, then replays it against the DUT.
module tb_multicycle_controller;

    typedef struct packed {
        logic       instr_ready;
        logic       ir_write;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       curr_flag;
        logic       pc_write;
        logic       illegal;
        logic [3:0] alu_op;
        logic [2:0] st;
    } ctl_t;

    typedef struct {
        logic valid;
        logic ready;
        logic clear;
        ctl_t exp;
    } cyc_t;

    localparam logic [2:0] ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXEC = 3'd2,
                           ST_MEM = 3'd3, ST_WB = 3'd4, ST_TRAP = 3'd5;

    localparam logic [6:0] OP_R = 7'b0110011, OP_LW = 7'b0000011, OP_SW = 7'b0100011,
                           OP_BR = 7'b1100011, OP_I = 7'b0010011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

    localparam int C_ILL = 0, C_R = 1, C_I = 2, C_LW = 3, C_SW = 4, C_BR = 5,
                   C_JAL = 6, C_JALR = 7, C_U = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       sel;
    logic       drv_valid, drv_ready, drv_clear;
    logic [6:0] drv_opcode;

    int total = 0;
    int bad   = 0;
    logic [31:0] cnt_a = 0;
    logic [31:0] cnt_b = 0;
    cyc_t trace[$];

    multicycle_controller_if #(.ALUOP_W(3), .CNT_W(4))  ifa ();
    multicycle_controller_if #(.ALUOP_W(4), .CNT_W(32)) ifb ();

    multicycle_controller #(.ALUOP_W(3), .EXT_UPPER(0), .MEM_TIMEOUT(4), .CNT_W(4)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.slave)
    );
    multicycle_controller #(.ALUOP_W(4), .EXT_UPPER(1), .MEM_TIMEOUT(15), .CNT_W(32)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.slave)
    );

    assign ifa.instr_valid = !sel && drv_valid;
    assign ifa.Opcode      = drv_opcode;
    assign ifa.mem_ready   = !sel && drv_ready;
    assign ifa.trap_clear  = !sel && drv_clear;
    assign ifb.instr_valid = sel && drv_valid;
    assign ifb.Opcode      = drv_opcode;
    assign ifb.mem_ready   = sel && drv_ready;
    assign ifb.trap_clear  = sel && drv_clear;

    ctl_t obs_a, obs_b;
    logic [31:0] ret_a, ret_b;
    assign obs_a = {ifa.instr_ready, ifa.IRWrite, ifa.ALUSrc, ifa.MemtoReg, ifa.RegWrite,
                    ifa.MemRead, ifa.MemWrite, ifa.Branch, ifa.Jump, ifa.CurrFlag,
                    ifa.PCWrite, ifa.Illegal, 1'b0, ifa.ALUOp, ifa.state_o};
    assign obs_b = {ifb.instr_ready, ifb.IRWrite, ifb.ALUSrc, ifb.MemtoReg, ifb.RegWrite,
                    ifb.MemRead, ifb.MemWrite, ifb.Branch, ifb.Jump, ifb.CurrFlag,
                    ifb.PCWrite, ifb.Illegal, ifb.ALUOp, ifb.state_o};
    assign ret_a = {28'b0, ifa.instret};
    assign ret_b = ifb.instret;

    function automatic ctl_t blank(input logic [2:0] st);
        ctl_t e;
        e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic int classify(input logic [6:0] opc, input logic ext);
        case (opc)
            OP_R:            return C_R;
            OP_I:            return C_I;
            OP_LW:           return C_LW;
            OP_SW:           return C_SW;
            OP_BR:           return C_BR;
            OP_JAL:          return C_JAL;
            OP_JALR:         return C_JALR;
            OP_LUI, OP_AUIPC: return ext ? C_U : C_ILL;
            default:         return C_ILL;
        endcase
    endfunction

    task automatic add_cycle(input ctl_t e, input logic v, input logic r, input logic c);
        cyc_t x;
        x.valid = v;
        x.ready = r;
        x.clear = c;
        x.exp   = e;
        trace.push_back(x);
    endtask

    task automatic trap_tail(input int hold);
        ctl_t e;
        e = blank(ST_TRAP);
        e.illegal = 1'b1;
        repeat (hold) add_cycle(e, 1'b0, 1'b0, 1'b0);
        add_cycle(e, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic add_wb(input int cls);
        ctl_t e;
        e = blank(ST_WB);
        e.reg_write  = 1'b1;
        e.mem_to_reg = (cls == C_LW);
        e.jump       = (cls == C_JAL) || (cls == C_JALR);
        e.curr_flag  = (cls == C_JALR);
        e.pc_write   = 1'b1;
        add_cycle(e, 1'b0, 1'b0, 1'b0);
    endtask

    // Expected trace of one instruction: idle FETCH cycles, handshake, DECODE,
    // then the class-specific tail (trap, EXEC, MEM waits, WB).
    task automatic build_trace(input logic [6:0] opc, input int idle, input int waits, input int hold);
        ctl_t e;
        int cls;
        int tmo;
        cls = classify(opc, sel);
        tmo = sel ? 15 : 4;
        trace.delete();
        for (int i = 0; i < idle; i++) begin
            e = blank(ST_FETCH);
            e.instr_ready = 1'b1;
            add_cycle(e, 1'b0, 1'b0, 1'b0);
        end
        e = blank(ST_FETCH);
        e.instr_ready = 1'b1;
        e.ir_write = 1'b1;
        add_cycle(e, 1'b1, 1'b0, 1'b0);
        add_cycle(blank(ST_DECODE), 1'b0, 1'b0, 1'b0);
        if (cls == C_ILL) begin
            trap_tail(hold);
        end else begin
            e = blank(ST_EXEC);
            case (cls)
                C_R:         e.alu_op = 4'b0010;
                C_I:         begin e.alu_src = 1'b1; e.alu_op = 4'b0000; end
                C_LW, C_SW:  begin e.alu_src = 1'b1; e.alu_op = 4'b0100; end
                C_BR:        begin e.alu_op = 4'b0001; e.branch = 1'b1; e.pc_write = 1'b1; end
                C_JAL, C_JALR: begin
                    e.alu_src = 1'b1; e.alu_op = 4'b0111; e.jump = 1'b1;
                    e.curr_flag = (cls == C_JALR);
                end
                default:     begin e.alu_src = 1'b1; e.alu_op = 4'b0110; end
            endcase
            add_cycle(e, 1'b0, 1'b0, 1'b0);
            if ((cls == C_LW) || (cls == C_SW)) begin
                e = blank(ST_MEM);
                e.alu_src   = 1'b1;
                e.alu_op    = 4'b0100;
                e.mem_read  = (cls == C_LW);
                e.mem_write = (cls == C_SW);
                if (waits >= tmo) begin
                    repeat (tmo) add_cycle(e, 1'b0, 1'b0, 1'b0);
                    trap_tail(hold);
                end else begin
                    repeat (waits) add_cycle(e, 1'b0, 1'b0, 1'b0);
                    e.pc_write = (cls == C_SW);
                    add_cycle(e, 1'b0, 1'b1, 1'b0);
                    if (cls == C_LW) add_wb(cls);
                end
            end else if (cls != C_BR) begin
                add_wb(cls);
            end
        end
    endtask

    // Replays a trace; inputs that cannot matter in a state are randomized.
    task automatic run_instr(input string name, input logic [6:0] opc, input int idle,
                             input int waits, input int hold);
        ctl_t obs;
        logic [31:0] want_ret, got_ret;
        build_trace(opc, idle, waits, hold);
        foreach (trace[i]) begin
            drv_valid  = trace[i].valid;
            drv_opcode = trace[i].valid ? opc : 7'($urandom);
            drv_ready  = (trace[i].exp.st == ST_MEM)  ? trace[i].ready : 1'($urandom);
            drv_clear  = (trace[i].exp.st == ST_TRAP) ? trace[i].clear : 1'($urandom);
            @(negedge clk);
            obs = sel ? obs_b : obs_a;
            total++;
            if (obs !== trace[i].exp) begin
                bad++;
                $display("[TB] FAIL %s ctl cyc%0d got=%b want=%b", name, i, obs, trace[i].exp);
            end
            want_ret = sel ? cnt_b : (cnt_a & 32'hF);
            got_ret  = sel ? ret_b : ret_a;
            total++;
            if (got_ret !== want_ret) begin
                bad++;
                $display("[TB] FAIL %s instret cyc%0d got=%0d want=%0d", name, i, got_ret, want_ret);
            end
            if (trace[i].exp.pc_write) begin
                if (sel) cnt_b++;
                else cnt_a++;
            end
            @(posedge clk);
            #1;
        end
        drv_valid = 1'b0;
        drv_ready = 1'b0;
        drv_clear = 1'b0;
    endtask

    task automatic test_reset();
        ctl_t zero, idle_exp, obs;
        logic [31:0] got;
        zero = '0;
        idle_exp = blank(ST_FETCH);
        idle_exp.instr_ready = 1'b1;
        reset = 1'b0;
        drv_valid = 1'b1;
        drv_opcode = OP_R;
        drv_ready = 1'b1;
        drv_clear = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            obs = s ? obs_b : obs_a;
            got = s ? ret_b : ret_a;
            total++;
            if (obs !== zero) begin
                bad++;
                $display("[TB] FAIL reset_ctl dut%0d got=%b want=%b", s, obs, zero);
            end
            total++;
            if (got !== 32'd0) begin
                bad++;
                $display("[TB] FAIL reset_instret dut%0d got=%0d want=0", s, got);
            end
        end
        drv_valid = 1'b0;
        drv_ready = 1'b0;
        drv_clear = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            obs = s ? obs_b : obs_a;
            total++;
            if (obs !== idle_exp) begin
                bad++;
                $display("[TB] FAIL release_ctl dut%0d got=%b want=%b", s, obs, idle_exp);
            end
        end
        @(posedge clk);
        #1;
        cnt_a = 0;
        cnt_b = 0;
    endtask

    task automatic test_rtype();
        sel = 1'b0;
        run_instr("rtype", OP_R, 0, 0, 0);
    endtask

    task automatic test_lw_wait();
        sel = 1'b1;
        run_instr("lw_wait3", OP_LW, 1, 3, 0);
        sel = 1'b0;
        run_instr("lw_wait3_tmo4", OP_LW, 0, 3, 0);
    endtask

    task automatic test_sw_timeout();
        sel = 1'b0;
        run_instr("sw_timeout", OP_SW, 1, 1000, 2);
        sel = 1'b1;
        run_instr("sw_timeout15", OP_SW, 0, 1000, 1);
        run_instr("sw_wait14", OP_SW, 0, 14, 0);
    endtask

    task automatic test_upper();
        sel = 1'b0;
        run_instr("lui_trap", OP_LUI, 0, 0, 1);
        run_instr("auipc_trap", OP_AUIPC, 0, 0, 0);
        sel = 1'b1;
        run_instr("lui_ok", OP_LUI, 0, 0, 0);
        run_instr("auipc_ok", OP_AUIPC, 0, 0, 0);
    endtask

    task automatic test_jump_branch();
        sel = 1'b1;
        run_instr("jalr", OP_JALR, 0, 0, 0);
        run_instr("jal", OP_JAL, 0, 0, 0);
        run_instr("beq", OP_BR, 1, 0, 0);
        run_instr("itype", OP_I, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        ctl_t zero, exp, obs;
        zero = '0;
        sel = 1'b1;
        drv_valid = 1'b1;
        drv_opcode = OP_LW;
        drv_ready = 1'b0;
        @(posedge clk);
        #1;
        drv_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        exp = blank(ST_MEM);
        exp.alu_src = 1'b1;
        exp.alu_op = 4'b0100;
        exp.mem_read = 1'b1;
        total++;
        if (obs_b !== exp) begin
            bad++;
            $display("[TB] FAIL mid_mem got=%b want=%b", obs_b, exp);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        drv_ready = 1'b1;
        #1;
        total++;
        if (obs_b !== zero) begin
            bad++;
            $display("[TB] FAIL mid_reset_ctl got=%b want=%b", obs_b, zero);
        end
        total++;
        if (ret_b !== 32'd0) begin
            bad++;
            $display("[TB] FAIL mid_reset_instret got=%0d want=0", ret_b);
        end
        @(negedge clk);
        reset = 1'b1;
        drv_ready = 1'b0;
        @(negedge clk);
        obs = obs_b;
        exp = blank(ST_FETCH);
        exp.instr_ready = 1'b1;
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL mid_release got=%b want=%b", obs, exp);
        end
        @(posedge clk);
        #1;
        cnt_a = 0;
        cnt_b = 0;
    endtask

    task automatic test_wrap();
        logic [31:0] start;
        sel = 1'b0;
        start = cnt_a;
        for (int n = 0; n < 16; n++) run_instr("wrap_br", OP_BR, 0, 0, 0);
        total++;
        if (ret_a !== ((start + 32'd16) & 32'hF)) begin
            bad++;
            $display("[TB] FAIL wrap got=%0d want=%0d", ret_a, (start + 32'd16) & 32'hF);
        end
    endtask

    task automatic test_back_to_back();
        sel = 1'b1;
        run_instr("b2b_r", OP_R, 0, 0, 0);
        run_instr("b2b_i", OP_I, 0, 0, 0);
        run_instr("b2b_sw", OP_SW, 0, 0, 0);
        run_instr("b2b_lw", OP_LW, 0, 0, 0);
        run_instr("b2b_jal", OP_JAL, 0, 0, 0);
        run_instr("b2b_br", OP_BR, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [6:0] ops [0:10];
        logic [6:0] opc;
        int pick, waits;
        ops = '{OP_R, OP_LW, OP_SW, OP_BR, OP_I, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_LW, OP_SW};
        for (int n = 0; n < 80; n++) begin
            sel = 1'($urandom);
            pick = $urandom_range(0, 11);
            opc = (pick == 11) ? 7'($urandom) : ops[pick];
            waits = sel ? $urandom_range(0, 17) : $urandom_range(0, 5);
            run_instr("random", opc, $urandom_range(0, 2), waits, $urandom_range(0, 2));
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b0;
        sel = 1'b0;
        drv_valid = 1'b0;
        drv_ready = 1'b0;
        drv_clear = 1'b0;
        drv_opcode = '0;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw_timeout();
        test_upper();
        test_jump_branch();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
